// File: rtl/net_link_responder.sv
// Link-side endpoint for the processor's four-wire network handshake: frames outbound
// payloads, filters inbound frames by node ID into a small FIFO, and serves receive requests.
module net_link_responder #(
  parameter logic [1:0] NODE_ID    = 2'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_send,
  input  logic [1:0] send_dest,
  input  logic [3:0] send_data,
  output logic       ack_sent,
  input  logic       req_receive,
  output logic       ack_received,
  output logic [3:0] recv_data,
  output logic       tx_valid,
  output logic [5:0] tx_frame,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [5:0] rx_frame,
  output logic [2:0] fifo_count,
  output logic [7:0] drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_ACK, S_WAIT_LOW} send_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT_LOW} recv_state_t;

  // Both requests come from the divided processor clock.
  logic [1:0] send_sync_reg;
  logic [1:0] recv_sync_reg;
  logic       req_send_s;
  logic       req_receive_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      send_sync_reg <= 2'b00;
      recv_sync_reg <= 2'b00;
    end else begin
      send_sync_reg <= {send_sync_reg[0], req_send};
      recv_sync_reg <= {recv_sync_reg[0], req_receive};
    end
  end

  assign req_send_s    = send_sync_reg[1];
  assign req_receive_s = recv_sync_reg[1];

  // Send path
  send_state_t send_state_reg, send_state_next;
  logic [5:0]  tx_frame_reg, tx_frame_next;
  logic        tx_valid_reg;
  logic        ack_sent_reg;

  always_comb begin
    send_state_next = send_state_reg;
    tx_frame_next   = tx_frame_reg;
    case (send_state_reg)
      S_IDLE: begin
        if (req_send_s) begin
          tx_frame_next   = {send_dest, send_data};
          send_state_next = S_TX;
        end
      end
      S_TX:       if (tx_ready) send_state_next = S_ACK;
      S_ACK:      if (!req_send_s) send_state_next = S_WAIT_LOW;
      S_WAIT_LOW: send_state_next = S_IDLE;
      default:    send_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      send_state_reg <= S_IDLE;
      tx_frame_reg   <= 6'd0;
      tx_valid_reg   <= 1'b0;
      ack_sent_reg   <= 1'b0;
    end else begin
      send_state_reg <= send_state_next;
      tx_frame_reg   <= tx_frame_next;
      tx_valid_reg   <= (send_state_next == S_TX);
      ack_sent_reg   <= (send_state_next == S_ACK);
    end
  end

  // Inbound FIFO
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    drop_count_reg;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          drop;

  recv_state_t recv_state_reg, recv_state_next;
  logic [3:0]  recv_data_reg;
  logic        ack_received_reg;

  assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
  assign pop       = (recv_state_reg == R_IDLE) && req_receive_s && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the frame.
  assign push      = rx_valid && (rx_frame[5:4] == NODE_ID) && (!fifo_full || pop);
  assign drop      = rx_valid && !push;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= rx_frame[3:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      drop_count_reg <= 8'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop && drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  // Receive path
  always_comb begin
    recv_state_next = recv_state_reg;
    case (recv_state_reg)
      R_IDLE:     if (pop) recv_state_next = R_ACK;
      R_ACK:      if (!req_receive_s) recv_state_next = R_WAIT_LOW;
      R_WAIT_LOW: recv_state_next = R_IDLE;
      default:    recv_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      recv_state_reg   <= R_IDLE;
      recv_data_reg    <= 4'd0;
      ack_received_reg <= 1'b0;
    end else begin
      recv_state_reg   <= recv_state_next;
      ack_received_reg <= (recv_state_next == R_ACK);
      if (pop) recv_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign ack_sent     = ack_sent_reg;
  assign tx_valid     = tx_valid_reg;
  assign tx_frame     = tx_frame_reg;
  assign ack_received = ack_received_reg;
  assign recv_data    = recv_data_reg;
  assign fifo_count   = 3'(count_reg);
  assign drop_count   = drop_count_reg;

endmodule

// File: tb/tb_net_link_responder.sv
// Self-checking bench for net_link_responder: vector table for the inbound filter, hand
// sequences for handshakes/corners, and a randomized phase against a queue-based model.
module tb_net_link_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_send;
  logic [1:0] send_dest;
  logic [3:0] send_data;
  logic       ack_sent;
  logic       req_receive;
  logic       ack_received;
  logic [3:0] recv_data;
  logic       tx_valid;
  logic [5:0] tx_frame;
  logic       tx_ready;
  logic       rx_valid;
  logic [5:0] rx_frame;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  net_link_responder #(.NODE_ID(2'd1), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_send(req_send), .send_dest(send_dest), .send_data(send_data), .ack_sent(ack_sent),
    .req_receive(req_receive), .ack_received(ack_received), .recv_data(recv_data),
    .tx_valid(tx_valid), .tx_frame(tx_frame), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_frame(rx_frame),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  typedef struct {
    logic [1:0] dest;
    logic [3:0] data;
    int         exp_count;
    int         exp_drop;
  } rx_vec_t;

  rx_vec_t tbl [8];
  int      model_q [$];
  int      model_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_send = 1'b0;
    req_receive = 1'b0;
    rx_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic send_rx(input logic [1:0] d, input logic [3:0] x);
    rx_frame = {d, x};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic recv_release();
    int n;
    req_receive = 1'b0;
    n = 0;
    while (ack_received !== 1'b0 && n < 20) begin tick(); n++; end
    chk("recv_release_latency", n, 3);
    tick();
  endtask

  task automatic recv_hs(input int exp_data);
    int n;
    req_receive = 1'b1;
    n = 0;
    while (ack_received !== 1'b1 && n < 20) begin tick(); n++; end
    chk("recv_latency", n, 3);
    chk("recv_data", recv_data, exp_data);
    $display("recv transaction: data=%0d fifo_count=%0d", recv_data, fifo_count);
    recv_release();
  endtask

  // Pop lands on the same edge as a push into a full FIFO.
  task automatic pop_with_push(input int exp_data, input logic [3:0] new_data);
    req_receive = 1'b1;
    tick();
    tick();
    send_rx(2'd1, new_data);
    chk("pp_ack", ack_received, 1);
    chk("pp_data", recv_data, exp_data);
    chk("pp_count", fifo_count, 4);
    $display("pop+push transaction: popped=%0d pushed=%0d", recv_data, new_data);
    recv_release();
  endtask

  task automatic start_send(input logic [1:0] d, input logic [3:0] x);
    int n;
    send_dest = d;
    send_data = x;
    req_send = 1'b1;
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("send_latency", n, 3);
    chk("send_frame", tx_frame, {26'd0, d, x});
  endtask

  task automatic send_release();
    int n;
    req_send = 1'b0;
    n = 0;
    while (ack_sent !== 1'b0 && n < 20) begin tick(); n++; end
    chk("send_release_latency", n, 3);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int d;
    int x;
    tbl[0] = '{2'd1, 4'd3, 1, 0};
    tbl[1] = '{2'd0, 4'd7, 1, 1};
    tbl[2] = '{2'd1, 4'd5, 2, 1};
    tbl[3] = '{2'd1, 4'd1, 3, 1};
    tbl[4] = '{2'd1, 4'd2, 4, 1};
    tbl[5] = '{2'd1, 4'd4, 4, 2};
    tbl[6] = '{2'd2, 4'd0, 4, 3};
    tbl[7] = '{2'd3, 4'd9, 4, 4};

    send_dest = 2'd0; send_data = 4'd0; tx_ready = 1'b0; rx_frame = 6'd0;
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ack_sent", ack_sent, 0);
    chk("rst_ack_received", ack_received, 0);
    chk("rst_tx_frame", tx_frame, 0);
    chk("rst_recv_data", recv_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_drop_count", drop_count, 0);

    // Basic send with the link ready
    tx_ready = 1'b1;
    start_send(2'd2, 4'hA);
    chk("send_frame_2A", tx_frame, 6'h2A);
    tick();
    chk("send_ack", ack_sent, 1);
    chk("send_valid_clear", tx_valid, 0);
    $display("send transaction: frame=%h", tx_frame);
    send_release();

    // Backpressure
    tx_ready = 1'b0;
    start_send(2'd3, 4'h5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", tx_valid, 1);
      chk("bp_frame", tx_frame, 6'h35);
      chk("bp_ack", ack_sent, 0);
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_ack_after_ready", ack_sent, 1);
    chk("bp_valid_after_ready", tx_valid, 0);
    $display("send transaction: frame=%h after backpressure", tx_frame);
    send_release();

    // Request withdrawn while the frame is still pending
    tx_ready = 1'b0;
    start_send(2'd0, 4'hC);
    req_send = 1'b0;
    repeat (4) tick();
    chk("drop_tx_still_valid", tx_valid, 1);
    tx_ready = 1'b1;
    tick();
    chk("drop_tx_ack_pulse", ack_sent, 1);
    tick();
    chk("drop_tx_ack_low", ack_sent, 0);
    tick();

    // Inbound filter table
    do_reset();
    foreach (tbl[i]) begin
      send_rx(tbl[i].dest, tbl[i].data);
      chk("tbl_count", fifo_count, tbl[i].exp_count);
      chk("tbl_drop", drop_count, tbl[i].exp_drop);
      $display("rx transaction: dest=%0d data=%0d count=%0d drop=%0d",
               tbl[i].dest, tbl[i].data, fifo_count, drop_count);
    end
    recv_hs(3);
    recv_hs(5);
    recv_hs(1);
    recv_hs(2);
    chk("tbl_drained", fifo_count, 0);

    // Receive stall on empty FIFO
    req_receive = 1'b1;
    repeat (8) tick();
    chk("stall_no_ack", ack_received, 0);
    send_rx(2'd1, 4'd9);
    n = 1;
    while (ack_received !== 1'b1 && n < 10) begin tick(); n++; end
    chk("stall_latency", n, 2);
    chk("stall_data", recv_data, 9);
    recv_release();

    // Full FIFO, then simultaneous push/pop across pointer wrap
    do_reset();
    for (int i = 1; i <= 5; i++) send_rx(2'd1, 4'(i));
    chk("full_count", fifo_count, 4);
    chk("full_drop", drop_count, 1);
    for (int i = 0; i < 4; i++) pop_with_push(1 + i, 4'(6 + i));
    for (int i = 0; i < 4; i++) recv_hs(6 + i);
    chk("wrap_drained", fifo_count, 0);
    chk("wrap_drop", drop_count, 1);

    // Randomized inbound traffic and receive handshakes against the queue model
    do_reset();
    model_q.delete();
    model_drop = 0;
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        d = $urandom_range(0, 3);
        x = $urandom_range(0, 15);
        send_rx(2'(d), 4'(x));
        if (d == 1 && model_q.size() < 4) model_q.push_back(x);
        else if (model_drop < 255) model_drop++;
        chk("rand_count", fifo_count, model_q.size());
        chk("rand_drop", drop_count, model_drop);
        repeat ($urandom_range(0, 2)) tick();
      end
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        if (model_q.size() == 0) begin
          req_receive = 1'b1;
          repeat (6) tick();
          chk("rand_stall", ack_received, 0);
          req_receive = 1'b0;
          repeat (4) tick();
        end else begin
          recv_hs(model_q.pop_front());
          chk("rand_pop_count", fifo_count, model_q.size());
        end
      end
    end

    // Drop counter saturation
    rx_frame = {2'd2, 4'd0};
    rx_valid = 1'b1;
    repeat (260) tick();
    rx_valid = 1'b0;
    model_drop = (model_drop + 260 > 255) ? 255 : model_drop + 260;
    chk("sat_drop", drop_count, model_drop);
    chk("sat_count", fifo_count, model_q.size());

    // Reset while sending and mid-receive
    do_reset();
    send_rx(2'd0, 4'd1);
    for (int i = 1; i <= 3; i++) send_rx(2'd1, 4'(i));
    req_receive = 1'b1;
    n = 0;
    while (ack_received !== 1'b1 && n < 20) begin tick(); n++; end
    chk("mid_recv_ack", ack_received, 1);
    chk("mid_fifo_two", fifo_count, 2);
    tx_ready = 1'b0;
    start_send(2'd1, 4'h7);
    chk("mid_recv_still_ack", ack_received, 1);
    reset = 1'b1;
    req_send = 1'b0;
    req_receive = 1'b0;
    tick();
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_ack_sent", ack_sent, 0);
    chk("mid_rst_ack_received", ack_received, 0);
    chk("mid_rst_fifo_count", fifo_count, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    chk("mid_rst_tx_frame", tx_frame, 0);
    chk("mid_rst_recv_data", recv_data, 0);
    repeat (2) tick();
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (6) tick();
    chk("post_rst_idle_valid", tx_valid, 0);
    chk("post_rst_idle_ack", ack_received, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/net_link_responder.md
# net_link_responder

Link-side endpoint for the processor's four-wire network handshake (send request/sent ack, receive request/received ack), taking the place of the external Arduino node. It accepts 4-bit payloads addressed to one of four nodes, frames them onto an outbound link, filters inbound frames by node ID into a 4-entry FIFO, and answers the processor's receive requests from that FIFO. Both processor-facing requests come from the divided processor clock, so they are synchronised here.

## Interface

Parameters:
- NODE_ID, 2'd0, this node's address; only inbound frames with this destination are accepted.
- FIFO_DEPTH, 4, inbound FIFO entries; must be a power of two.

Ports:
- clock  in  1  block clock.
- reset  in  1  synchronous, active-high.
- req_send  in  1  processor send request (level); asynchronous to `clock`.
- send_dest  in  2  destination node; stable while `req_send` is high.
- send_data  in  4  payload; stable while `req_send` is high.
- ack_sent  out  1  send acknowledge to the processor.
- req_receive  in  1  processor receive request (level); asynchronous to `clock`.
- ack_received  out  1  receive acknowledge to the processor.
- recv_data  out  4  received payload; valid while `ack_received` is high.
- tx_valid  out  1  outbound frame valid.
- tx_frame  out  6  outbound frame, {dest[1:0], data[3:0]}.
- tx_ready  in  1  link accepts the frame when `tx_valid & tx_ready`.
- rx_valid  in  1  inbound frame strobe, one cycle per frame.
- rx_frame  in  6  inbound frame, {dest[1:0], data[3:0]}.
- fifo_count  out  3  current inbound FIFO occupancy.
- drop_count  out  8  count of dropped inbound frames; saturates at 255.

## Operation

- **Input synchronisation:** `req_send` and `req_receive` each pass through a two-flop synchroniser before use. `send_dest` and `send_data` are sampled only once the synchronised request is high; they are stable by then.

- **Send FSM** (`S_IDLE`, `S_TX`, `S_ACK`, `S_WAIT_LOW`):
  - `S_IDLE`: on synchronised `req_send` = 1, latch {`send_dest`, `send_data`} into `tx_frame` and go to `S_TX`.
  - `S_TX`: `tx_valid` = 1. When `tx_ready` = 1, go to `S_ACK`.
  - `S_ACK`: `ack_sent` = 1. When synchronised `req_send` = 0, go to `S_WAIT_LOW`.
  - `S_WAIT_LOW`: `ack_sent` = 0 for one cycle, then go to `S_IDLE`. This guarantees the acknowledge has a low gap before the next request is accepted.
  - If `req_send` drops while in `S_TX`, the frame is still sent. The FSM goes to `S_ACK`, emits a 1-cycle `ack_sent`, then continues normally.

- **Inbound filter:** on `rx_valid`, if `rx_frame[5:4]` == NODE_ID and the FIFO is not full, push `rx_frame[3:0]`. Otherwise increment `drop_count`. This covers both the wrong-destination case and the FIFO-full case. `drop_count` saturates at 255.

- **Receive FSM** (`R_IDLE`, `R_ACK`, `R_WAIT_LOW`):
  - `R_IDLE`: when synchronised `req_receive` = 1 and `fifo_count` != 0, pop the head into `recv_data` and go to `R_ACK`. If the FIFO is empty, stay in `R_IDLE` with the request pending; the processor stalls.
  - `R_ACK`: `ack_received` = 1, `recv_data` held. On synchronised `req_receive` = 0, go to `R_WAIT_LOW`.
  - `R_WAIT_LOW`: one cycle, then go to `R_IDLE`.

- **Simultaneous push and pop:** occupancy is unchanged and both operations complete. A push into a full FIFO in the same cycle as a pop is accepted.

- **FIFO pointers:** write and read pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. `fifo_count` is 0..FIFO_DEPTH.

- **Reset (any state):**
  - Both FSMs return to idle and the FIFO is flushed.
  - `ack_sent`, `ack_received`, `tx_valid` = 0; `tx_frame`, `recv_data` = 0; `fifo_count`, `drop_count` = 0.
  - Synchroniser flops clear.
  - A frame in flight in `S_TX` is abandoned.

## Timing

- Send:
  - `req_send` rising to `tx_valid` high: 3 cycles (2 synchroniser flops + latch).
  - The handshake `tx_valid & tx_ready` to `ack_sent` high: 1 cycle.
  - `req_send` falling to `ack_sent` low: 3 cycles.
- Receive:
  - `req_receive` rising with a non-empty FIFO to `ack_received` high: 3 cycles, with `recv_data` valid in the same cycle.
  - `req_receive` falling to `ack_received` low: 3 cycles.
- Inbound: `rx_valid` to `fifo_count` update is 1 cycle; a pushed entry is poppable the next cycle.
- All outputs are registered.

## Test plan

- **Send:** reset, then `req_send` = 1 with dest = 2, data = 4'hA, and `tx_ready` = 1.
  - Required: `tx_valid` with `tx_frame` = 6'h2A within 3 cycles, then `ack_sent` = 1.
  - Drop `req_send`: `ack_sent` returns to 0 within 3 cycles.
- **Backpressure:** hold `tx_ready` = 0 for 10 cycles.
  - Required: `tx_valid` and `tx_frame` held stable and `ack_sent` = 0 until `tx_ready` rises; `ack_sent` rises 1 cycle later.
- **Filter and order:** NODE_ID = 1; inject frames {1,3}, {0,7}, {1,5}.
  - Required: `fifo_count` = 2, `drop_count` = 1.
  - Two receive handshakes return `recv_data` = 3 then 5, in order.
- **Full FIFO:** inject 5 matching frames 1..5.
  - Required: `fifo_count` = 4, `drop_count` = 1.
  - A following pop returns 1; the FIFO pointers wrap correctly over a further 4 push/pop pairs.
- **Receive stall:** `req_receive` = 1 with the FIFO empty.
  - Required: `ack_received` stays 0.
  - Inject a matching frame with data = 9: `ack_received` = 1 with `recv_data` = 9 within 2 cycles.
- **Reset mid-operation:** assert reset while in `S_TX` and in `R_ACK` with the FIFO holding 2 entries.
  - Required: next cycle `tx_valid` = 0, `ack_sent` = 0, `ack_received` = 0, `fifo_count` = 0, `drop_count` = 0.
